// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the instruction/data memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT_IF = 2'd1,
    ST_GNT_D  = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_D    = 2'b10
  } owner_e;

  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_timeout_ctr.sv
// rtl/arb_timeout_ctr.sv - grant-state watchdog; expire_o fires on the TIMEOUT-th enabled cycle
module arb_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expire_o = enable_i && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fixed-priority (data over fetch) arbiter for one shared memory port
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ack,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic [1:0]    owner,
  output logic          err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT must be at least 1");
  end

  arb_state_e    state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          in_gnt;
  logic          tmo_expire;

  assign in_gnt = (state_q == ST_GNT_IF) || (state_q == ST_GNT_D);

`ifdef ARB_TIMEOUT_EN
  logic err_q, err_d;

  arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (state_q == ST_IDLE),
    .enable_i (in_gnt && !m_ack),
    .expire_o (tmo_expire)
  );

  assign err_d = err_q | tmo_expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign tmo_expire = 1'b0;
  assign err        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (d_req) begin
          state_d   = ST_GNT_D;
          owner_d   = OWN_D;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
        end else if (if_req) begin
          state_d   = ST_GNT_IF;
          owner_d   = OWN_IF;
          m_we_d    = 1'b0;
          m_addr_d  = if_addr;
          m_wdata_d = '0;
        end
      end
      ST_GNT_IF, ST_GNT_D: begin
        // A real completion wins over a watchdog expiry landing in the same cycle.
        if (m_ack || tmo_expire) begin
          state_d = ST_RESP;
          if (state_q == ST_GNT_IF) begin
            if_rdata_d = m_ack ? m_rdata : DW'(ABORT_DATA);
          end else if (!m_we_q) begin
            d_rdata_d = m_ack ? m_rdata : DW'(ABORT_DATA);
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_NONE;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Handshake outputs decode the state register so an async reset kills them at once.
  assign m_req    = in_gnt;
  assign if_ack   = (state_q == ST_RESP) && (owner_q == OWN_IF);
  assign d_ack    = (state_q == ST_RESP) && (owner_q == OWN_D);
  assign busy     = (state_q != ST_IDLE);
  assign owner    = owner_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        busy;
  logic [1:0]  owner;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .busy(busy), .owner(owner), .err(err)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    step();
    checks++; if ({m_req, m_we, if_ack, d_ack, busy, err, owner} !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %b required 00000000", {m_req, m_we, if_ack, d_ack, busy, err, owner}); end
    checks++; if ({m_addr, m_wdata} !== 64'h0) begin errors++; $display("FAIL reset_m_regs: got %h required 0", {m_addr, m_wdata}); end
    checks++; if ({if_rdata, d_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h required 0", {if_rdata, d_rdata}); end
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_wait2();
    if_req = 1'b1; if_addr = 32'h40;
    step();
    checks++; if ({m_req, m_we, owner, busy} !== 5'b10011) begin errors++; $display("FAIL fetch_grant: got %b required 10011", {m_req, m_we, owner, busy}); end
    checks++; if (m_addr !== 32'h40) begin errors++; $display("FAIL fetch_addr: got %h required 00000040", m_addr); end
    step();
    step();
    m_ack = 1'b1; m_rdata = 32'h8C01_0004;
    step();
    m_ack = 1'b0; m_rdata = '0;
    checks++; if ({if_ack, d_ack, m_req} !== 3'b100) begin errors++; $display("FAIL fetch_ack: got %b required 100", {if_ack, d_ack, m_req}); end
    checks++; if (if_rdata !== 32'h8C01_0004) begin errors++; $display("FAIL fetch_rdata: got %h required 8c010004", if_rdata); end
    if_req = 1'b0;
    step();
    checks++; if ({if_ack, owner, busy} !== 4'b0000) begin errors++; $display("FAIL fetch_idle: got %b required 0000", {if_ack, owner, busy}); end
    checks++; if (if_rdata !== 32'h8C01_0004) begin errors++; $display("FAIL fetch_rdata_hold: got %h required 8c010004", if_rdata); end
  endtask

  task automatic test_priority();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h44;
    step();
    checks++; if ({m_req, owner} !== 3'b110) begin errors++; $display("FAIL prio_owner: got %b required 110", {m_req, owner}); end
    checks++; if (m_addr !== 32'h100) begin errors++; $display("FAIL prio_addr: got %h required 00000100", m_addr); end
    m_ack = 1'b1; m_rdata = 32'hA5A5_0001;
    step();
    m_ack = 1'b0;
    checks++; if ({d_ack, if_ack, m_req} !== 3'b100) begin errors++; $display("FAIL prio_d_ack: got %b required 100", {d_ack, if_ack, m_req}); end
    checks++; if (d_rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL prio_d_rdata: got %h required a5a50001", d_rdata); end
    d_req = 1'b0;
    step();
    checks++; if ({m_req, owner, busy} !== 4'b0000) begin errors++; $display("FAIL prio_gap: got %b required 0000", {m_req, owner, busy}); end
    step();
    checks++; if ({m_req, owner} !== 3'b101) begin errors++; $display("FAIL prio_fetch_grant: got %b required 101", {m_req, owner}); end
    checks++; if (m_addr !== 32'h44) begin errors++; $display("FAIL prio_fetch_addr: got %h required 00000044", m_addr); end
    m_ack = 1'b1; m_rdata = 32'h0000_1111;
    step();
    m_ack = 1'b0;
    checks++; if ({if_ack, if_rdata} !== {1'b1, 32'h0000_1111}) begin errors++; $display("FAIL prio_fetch_ack: got %b/%h required 1/00001111", if_ack, if_rdata); end
    if_req = 1'b0;
    step();
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h104; d_wdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({m_req, m_we, m_addr, m_wdata} !== {2'b11, 32'h104, 32'h1234_5678}) begin errors++; $display("FAIL store_hold_%0d: got %b%b %h %h required 11 00000104 12345678", i, m_req, m_we, m_addr, m_wdata); end
    end
    m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
    step();
    m_ack = 1'b0;
    checks++; if ({d_ack, m_req} !== 2'b10) begin errors++; $display("FAIL store_ack: got %b required 10", {d_ack, m_req}); end
    checks++; if (d_rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL store_d_rdata: got %h required a5a50001", d_rdata); end
    d_req = 1'b0; d_we = 1'b0;
    step();
    checks++; if ({d_ack, busy} !== 2'b00) begin errors++; $display("FAIL store_idle: got %b required 00", {d_ack, busy}); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_mreq, exp_ack, got_mreq, got_ack;
    exp_mreq = 9'b001001001;
    exp_ack  = 9'b010010010;
    if_req = 1'b1; if_addr = 32'h48;
    m_ack = 1'b1; m_rdata = 32'h0BAD_F00D;
    for (int i = 0; i < 9; i++) begin
      step();
      got_mreq[i] = m_req;
      got_ack[i]  = if_ack;
      checks++; if (m_req && (if_ack || d_ack)) begin errors++; $display("FAIL b2b_req_in_resp_%0d: got m_req=1 with ack required m_req=0", i); end
    end
    if_req = 1'b0; m_ack = 1'b0;
    checks++; if (got_mreq !== exp_mreq) begin errors++; $display("FAIL b2b_mreq_pattern: got %b required %b", got_mreq, exp_mreq); end
    checks++; if (got_ack !== exp_ack) begin errors++; $display("FAIL b2b_ack_pattern: got %b required %b", got_ack, exp_ack); end
    checks++; if (if_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL b2b_rdata: got %h required 0badf00d", if_rdata); end
    step();
    checks++; if ({m_req, busy} !== 2'b00) begin errors++; $display("FAIL b2b_ack_in_idle: got %b required 00", {m_req, busy}); end
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    step();
    checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b required 1", m_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({m_req, if_ack, d_ack, busy, owner} !== 6'b0) begin errors++; $display("FAIL rstmid_ctrl: got %b required 000000", {m_req, if_ack, d_ack, busy, owner}); end
    checks++; if ({m_addr, if_rdata, d_rdata} !== 96'h0) begin errors++; $display("FAIL rstmid_regs: got %h required 0", {m_addr, if_rdata, d_rdata}); end
    d_req = 1'b0;
    step();
    rst_n = 1'b1;
    if_req = 1'b1; if_addr = 32'h60;
    step();
    checks++; if ({m_req, owner, m_addr} !== {3'b101, 32'h60}) begin errors++; $display("FAIL rstmid_regrant: got %b %h required 101 00000060", {m_req, owner}, m_addr); end
    m_ack = 1'b1; m_rdata = 32'h0000_6060;
    step();
    m_ack = 1'b0;
    checks++; if ({if_ack, if_rdata} !== {1'b1, 32'h0000_6060}) begin errors++; $display("FAIL rstmid_ack: got %b/%h required 1/00006060", if_ack, if_rdata); end
    if_req = 1'b0;
    step();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b required 0", err); end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    n = 0;
    if_req = 1'b1; if_addr = 32'h70;
    step();
    while (m_req === 1'b1 && n < 40) begin
      n++;
      step();
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL tmo_cycles: got %0d required 16", n); end
    checks++; if ({if_ack, if_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin errors++; $display("FAIL tmo_abort: got %b/%h required 1/deadbeef", if_ack, if_rdata); end
    if_req = 1'b0;
    repeat (4) step();
    checks++; if ({err, busy} !== 2'b10) begin errors++; $display("FAIL tmo_err_sticky: got %b required 10", {err, busy}); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_err_reset: got %b required 0", err); end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_wait2();
    test_priority();
    test_store();
    test_back_to_back();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
